// File: rtl/dcache_lsu.sv
// dcache_lsu: one-op load/store initiator for the D-cache CPU port.
// Optional LSU_MISALIGN_CHK_EN rejects misaligned H/W accesses.
module dcache_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              LSU_VALID,
    output logic              LSU_READY,
    input  logic              LSU_WE,
    input  logic [2:0]        LSU_FUNCT3,
    input  logic [ADDR_W-1:0] LSU_ADDR,
    input  logic [DATA_W-1:0] LSU_WDATA,
    output logic              LSU_RESP_VALID,
    output logic [DATA_W-1:0] LSU_RESP_DATA,
    output logic              LSU_RESP_ERR,
    output logic              CPU_REQ,
    output logic [ADDR_W-1:0] CPU_REQ_ADDR,
    input  logic              CPU_REQ_VALID,
    input  logic [DATA_W-1:0] CPU_REQ_DATA,
    output logic              CPU_WR_EN,
    output logic [DATA_W-1:0] CPU_WR_DATA,
    output logic [3:0]        CPU_WR_STRB,
    input  logic              BUSY
);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, WR_WAIT_HI, WR_WAIT_LO, GAP, RESP
    } state_t;

    state_t            state, state_nx;
    logic              accept, req_err, f3_ok, misalign;
    logic              op_we, op_err;
    logic [2:0]        op_f3;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata, rd_word;
    logic              rd_act, wr_act;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [DATA_W-1:0] ld_ext;

    assign accept = LSU_VALID & LSU_READY;

    // Classify the incoming op: legal funct3 for its direction, plus alignment
    always_comb begin
        f3_ok = 1'b0;
        case (LSU_FUNCT3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~LSU_WE;
            default:                f3_ok = 1'b0;
        endcase
`ifdef LSU_MISALIGN_CHK_EN
        misalign = ((LSU_FUNCT3[1:0] == 2'b01) & LSU_ADDR[0])
                 | ((LSU_FUNCT3 == 3'b010) & (|LSU_ADDR[1:0]));
`else
        misalign = 1'b0;
`endif
        req_err = ~f3_ok | misalign;
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nx;
    end

    // Op capture on accept, read word capture on cache return
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            op_we    <= 1'b0;
            op_err   <= 1'b0;
            op_f3    <= 3'b000;
            op_addr  <= '0;
            op_wdata <= '0;
            rd_word  <= '0;
        end else begin
            if (accept) begin
                op_we    <= LSU_WE;
                op_err   <= req_err;
                op_f3    <= LSU_FUNCT3;
                op_addr  <= LSU_ADDR;
                op_wdata <= LSU_WDATA;
            end
            if (state == RD_WAIT && CPU_REQ_VALID)
                rd_word <= CPU_REQ_DATA;
        end
    end

    // Next-state logic; a store completes on the BUSY falling edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)     state_nx = RESP;
                else if (LSU_WE) state_nx = WR_WAIT_HI;
                else             state_nx = RD_WAIT;
            end
            RD_WAIT:    if (CPU_REQ_VALID) state_nx = GAP;
            WR_WAIT_HI: if (BUSY)          state_nx = WR_WAIT_LO;
            WR_WAIT_LO: if (!BUSY)         state_nx = GAP;
            GAP:        state_nx = RESP;
            RESP:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Outputs: request lanes only while waiting, extended data only in RESP
    always_comb begin
        rd_act    = (state == RD_WAIT);
        wr_act    = (state == WR_WAIT_HI) | (state == WR_WAIT_LO);
        LSU_READY = (state == IDLE) & ~BUSY;
        CPU_REQ   = rd_act;
        CPU_WR_EN = wr_act;
        CPU_REQ_ADDR = '0;
        if (rd_act | wr_act)
            CPU_REQ_ADDR = {op_addr[ADDR_W-1:2], 2'b00};
        CPU_WR_DATA = '0;
        CPU_WR_STRB = 4'b0000;
        if (wr_act) begin
            case (op_f3[1:0])
                2'b00: begin
                    CPU_WR_DATA = {4{op_wdata[7:0]}};
                    CPU_WR_STRB = 4'b0001 << op_addr[1:0];
                end
                2'b01: begin
                    CPU_WR_DATA = {2{op_wdata[15:0]}};
                    CPU_WR_STRB = 4'b0011 << {op_addr[1], 1'b0};
                end
                default: begin
                    CPU_WR_DATA = op_wdata;
                    CPU_WR_STRB = 4'b1111;
                end
            endcase
        end
        case (op_addr[1:0])
            2'b00:   ld_b = rd_word[7:0];
            2'b01:   ld_b = rd_word[15:8];
            2'b10:   ld_b = rd_word[23:16];
            default: ld_b = rd_word[31:24];
        endcase
        ld_h = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_f3)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_ext = {24'h0, ld_b};
            3'b101:  ld_ext = {16'h0, ld_h};
            default: ld_ext = rd_word;
        endcase
        LSU_RESP_VALID = (state == RESP);
        LSU_RESP_ERR   = (state == RESP) & op_err;
        LSU_RESP_DATA  = '0;
        if (state == RESP && !op_we && !op_err)
            LSU_RESP_DATA = ld_ext;
    end

endmodule

// File: tb/tb_dcache_lsu.sv
// tb_dcache_lsu: directed vector bench with a small responding cache model.
// Honours LSU_MISALIGN_CHK_EN for the misaligned-load expectations.
module tb_dcache_lsu;

    logic        clk, rst_n;
    logic        lsu_valid, lsu_ready, lsu_we;
    logic [2:0]  lsu_f3;
    logic [31:0] lsu_addr, lsu_wdata, resp_data;
    logic        resp_valid, resp_err;
    logic        cpu_req, cpu_wr_en, cpu_valid;
    logic [31:0] cpu_addr, cpu_rdata, cpu_wdata;
    logic [3:0]  cpu_strb;
    logic        busy, model_busy, man_busy, model_en;

    int checks = 0;
    int errors = 0;
    localparam int RD_LAT = 2;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tv[19];
    logic [31:0] mem[64];

    assign busy = model_busy | man_busy;

    dcache_lsu dut (
        .ACLK(clk), .ARESETn(rst_n),
        .LSU_VALID(lsu_valid), .LSU_READY(lsu_ready),
        .LSU_WE(lsu_we), .LSU_FUNCT3(lsu_f3),
        .LSU_ADDR(lsu_addr), .LSU_WDATA(lsu_wdata),
        .LSU_RESP_VALID(resp_valid), .LSU_RESP_DATA(resp_data),
        .LSU_RESP_ERR(resp_err),
        .CPU_REQ(cpu_req), .CPU_REQ_ADDR(cpu_addr),
        .CPU_REQ_VALID(cpu_valid), .CPU_REQ_DATA(cpu_rdata),
        .CPU_WR_EN(cpu_wr_en), .CPU_WR_DATA(cpu_wdata),
        .CPU_WR_STRB(cpu_strb), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache responder: store -> BUSY pulse of two cycles; load -> busy, then VALID
    initial begin
        model_busy = 1'b0;
        cpu_valid  = 1'b0;
        cpu_rdata  = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (model_en && rst_n && cpu_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (cpu_strb[b])
                        mem[cpu_addr[7:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
                @(negedge clk);
                model_busy = 1'b1;
                repeat (2) @(negedge clk);
                model_busy = 1'b0;
                while (cpu_wr_en) @(negedge clk);
            end else if (model_en && rst_n && cpu_req) begin
                model_busy = 1'b1;
                repeat (RD_LAT) @(negedge clk);
                model_busy = 1'b0;
                cpu_valid  = 1'b1;
                cpu_rdata  = mem[cpu_addr[7:2]];
                @(negedge clk);
                cpu_valid  = 1'b0;
                while (cpu_req) @(negedge clk);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic ee,
                                input logic [3:0] es, input logic [31:0] ew);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee; v.exp_strb = es; v.exp_wd = ew;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!lsu_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_ready"}, 32'(lsu_ready), 32'd1);
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int lat = 0;
        int act = 0;
        bit hold_ok = 1'b1;
        bit quiet = 1'b0;
        string nm = $sformatf("op%0d", idx);
        wait_ready(nm);
        lsu_valid = 1'b1; lsu_we = v.we; lsu_f3 = v.f3;
        lsu_addr = v.addr; lsu_wdata = v.wdata;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        while (!resp_valid && lat < 50) begin
            if (cpu_req || cpu_wr_en) begin
                act++;
                if (cpu_addr !== {v.addr[31:2], 2'b00}) hold_ok = 1'b0;
                if (cpu_wr_en && (cpu_strb !== v.exp_strb ||
                    cpu_wdata !== v.exp_wd)) hold_ok = 1'b0;
            end
            quiet = !cpu_req && !cpu_wr_en && cpu_strb == 4'b0 &&
                    cpu_wdata == 32'b0;
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_data"}, resp_data, v.exp_data);
        chk({nm, "_err"}, 32'(resp_err), 32'(v.exp_err));
        if (v.exp_err) begin
            chk({nm, "_no_access"}, act, 0);
            chk({nm, "_err_lat_le1"}, 32'(lat <= 1), 32'd1);
        end else begin
            chk({nm, "_hold"}, 32'(hold_ok), 32'd1);
            chk({nm, "_active_cycles"}, act, v.we ? 4 : RD_LAT + 1);
            chk({nm, "_latency"}, lat, v.we ? 5 : RD_LAT + 2);
            chk({nm, "_gap"}, 32'(quiet), 32'd1);
        end
        @(posedge clk); #1;
        chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        tv[0]  = mk(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 4'hF, 32'hDEADBEEF);
        tv[1]  = mk(0, 3'b010, 32'h40, 0, 32'hDEADBEEF, 0, 0, 0);
        tv[2]  = mk(1, 3'b000, 32'h43, 32'h80, 0, 0, 4'h8, 32'h80808080);
        tv[3]  = mk(0, 3'b000, 32'h43, 0, 32'hFFFFFF80, 0, 0, 0);
        tv[4]  = mk(0, 3'b100, 32'h43, 0, 32'h00000080, 0, 0, 0);
        tv[5]  = mk(1, 3'b001, 32'h42, 32'h1234, 0, 0, 4'hC, 32'h12341234);
        tv[6]  = mk(0, 3'b010, 32'h40, 0, 32'h1234BEEF, 0, 0, 0);
        tv[7]  = mk(0, 3'b001, 32'h42, 0, 32'h00001234, 0, 0, 0);
        tv[8]  = mk(0, 3'b001, 32'h40, 0, 32'hFFFFBEEF, 0, 0, 0);
        tv[9]  = mk(0, 3'b101, 32'h40, 0, 32'h0000BEEF, 0, 0, 0);
        tv[10] = mk(0, 3'b000, 32'h41, 0, 32'hFFFFFFBE, 0, 0, 0);
        tv[11] = mk(1, 3'b000, 32'h44, 32'h1A5, 0, 0, 4'h1, 32'hA5A5A5A5);
        tv[12] = mk(0, 3'b100, 32'h44, 0, 32'h000000A5, 0, 0, 0);
        tv[13] = mk(0, 3'b000, 32'h44, 0, 32'hFFFFFFA5, 0, 0, 0);
        tv[14] = mk(1, 3'b100, 32'h44, 32'h77, 0, 1, 0, 0);
        tv[15] = mk(0, 3'b011, 32'h40, 0, 0, 1, 0, 0);
        tv[16] = mk(1, 3'b111, 32'h40, 32'h99, 0, 1, 0, 0);
`ifdef LSU_MISALIGN_CHK_EN
        tv[17] = mk(0, 3'b001, 32'h41, 0, 0, 1, 0, 0);
        tv[18] = mk(0, 3'b010, 32'h42, 0, 0, 1, 0, 0);
`else
        tv[17] = mk(0, 3'b001, 32'h41, 0, 32'hFFFFBEEF, 0, 0, 0);
        tv[18] = mk(0, 3'b010, 32'h42, 0, 32'h1234BEEF, 0, 0, 0);
`endif
        rst_n = 1'b0; model_en = 1'b1; man_busy = 1'b0;
        lsu_valid = 1'b0; lsu_we = 1'b0; lsu_f3 = 3'b000;
        lsu_addr = '0; lsu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {resp_valid, resp_err, cpu_req, cpu_wr_en,
            cpu_strb} | resp_data | cpu_addr | cpu_wdata, 32'd0);
        chk("reset_ready", 32'(lsu_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) run_op(i, tv[i]);

        // Reset while the store waits for BUSY to fall
        model_en = 1'b0;
        wait_ready("rst_seq");
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_f3 = 3'b010;
        lsu_addr = 32'h48; lsu_wdata = 32'h55;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("rst_wr_en_hi", 32'(cpu_wr_en), 32'd1);
        man_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_wr_en_lo", 32'(cpu_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en_drop", 32'(cpu_wr_en), 32'd0);
        chk("rst_ready_busy", 32'(lsu_ready), 32'd0);
        man_busy = 1'b0;
        #1;
        chk("rst_ready_idle", 32'(lsu_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid || cpu_wr_en) seen++;
        end
        chk("rst_no_replay", seen, 0);
        model_en = 1'b1;
        run_op(19, mk(0, 3'b010, 32'h40, 0, 32'h1234BEEF, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
